// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the framed UART receiver: FSM state
// encoding, parity-mode codes and a helper that derives the bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Rounded number of clk cycles per bit for a given clock and baud rate.
  function automatic int clks_per_bit(input longint unsigned clk_hz,
                                      input longint unsigned baud);
    return int'((clk_hz + baud / 2) / baud);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VAL so the synchronized output starts at the line's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so q takes the old meta, giving two real stages.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
`timescale 1ns/1ps
// Framed UART receiver: start/data/optional parity/stop, mid-bit sampling,
// one-word output register with valid/ready handshake and overrun pulse.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined;
// otherwise the PAR state is never entered and parity_err is tied low.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

`ifdef UART_RX_PARITY_EN
  localparam int PAR_MODE = PARITY;
`else
  // PARITY is accepted for interface compatibility but has no effect here.
  localparam int PAR_MODE = (PARITY >= 0) ? PAR_NONE : PAR_NONE;
`endif

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] IDX_STOP_LAST = 4'(STOP_BITS - 1);

  logic                 rxs;
  uart_rx_state_t       state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 armed;
  logic                 ferr_acc;
  logic                 load_pend;

  logic cnt_clr, idx_clr, idx_inc, shift_en;
  logic frame_begin, stop_smp, frame_done;
`ifdef UART_RX_PARITY_EN
  logic par_smp;
  logic perr_acc;
`endif

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_nx    = state;
    cnt_clr     = 1'b0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    shift_en    = 1'b0;
    frame_begin = 1'b0;
    stop_smp    = 1'b0;
    frame_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp     = 1'b0;
`endif
    case (state)
      IDLE: begin
        // After a frame error the line must go high again before a new start.
        if (!rxs && armed) begin
          state_nx = START;
          cnt_clr  = 1'b1;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          if (rxs) begin
            state_nx = IDLE;
          end else begin
            state_nx    = DATA;
            cnt_clr     = 1'b1;
            idx_clr     = 1'b1;
            frame_begin = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == IDX_DATA_LAST) begin
            idx_clr  = 1'b1;
            state_nx = (PAR_MODE != PAR_NONE) ? PAR : STOP;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (cnt == CNT_LAST) begin
          par_smp  = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          stop_smp = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == IDX_STOP_LAST) begin
            idx_clr    = 1'b1;
            frame_done = 1'b1;
            state_nx   = IDLE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit-period counter and bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if (cnt_clr)             cnt <= '0;
      else if (state != IDLE)  cnt <= cnt + 1'b1;
      if (idx_clr)             bit_idx <= '0;
      else if (idx_inc)        bit_idx <= bit_idx + 1'b1;
    end
  end

  // Data shift register, LSB received first.
  always_ff @(posedge clk) begin
    // NOTE: datapath only; every bit is overwritten before it is used, so no reset.
    if (shift_en) shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
  end

  // Per-frame status: stop-bit error, re-arm after error, load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b1;
      ferr_acc  <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      load_pend <= frame_done;
      if (frame_begin)           ferr_acc <= 1'b0;
      else if (stop_smp && !rxs) ferr_acc <= 1'b1;
      if (stop_smp && !rxs)      armed <= 1'b0;
      else if (rxs)              armed <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check: even compares against XOR of data, odd against its inverse.
  always_ff @(posedge clk) begin
    if (rst)              perr_acc <= 1'b0;
    else if (frame_begin) perr_acc <= 1'b0;
    else if (par_smp)     perr_acc <= rxs ^ (^shift_q) ^ (PAR_MODE == PAR_ODD);
  end
`else
  assign parity_err = 1'b0;
`endif

  // Output word register with handshake; a load onto an unaccepted word drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      overrun_err <= 1'b0;
      if (load_pend) begin
        if (valid_out && !ready_in) begin
          overrun_err <= 1'b1;
        end else begin
          data_out   <= shift_q;
          frame_err  <= ferr_acc;
          valid_out  <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= perr_acc;
`endif
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_framed: a transaction-level model predicts
// each word (data, frame/parity error) and whether it is dropped; a compare
// process checks every cycle valid_out is high. Directed cases plus random frames.
module tb_uart_rx_framed;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_RX_PARITY_EN
  localparam int TB_PARITY = 1;
`else
  localparam int TB_PARITY = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          ready_in;
  logic [DB-1:0] data_out;
  logic          valid_out, frame_err, parity_err, overrun_err, busy;

  always #5 clk = ~clk;

  uart_rx_framed #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY      (TB_PARITY),
    .STOP_BITS   (SB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  typedef struct {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } word_t;

  word_t         exp_q[$];
  int            tests    = 0;
  int            fails    = 0;
  int            accepts  = 0;
  int            ovr_seen = 0;
  int            ovr_exp  = 0;
  logic [DB-1:0] last_data;
  logic          last_ferr, last_perr;
  int            base, ovr_base, n;
  logic [DB-1:0] d;
  logic          bp, bs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic b, input int cycles);
    rx = b;
    repeat (cycles) tick();
  endtask

  // Send one frame; the model decides at the stop bit whether it is kept or dropped.
  task automatic send_frame(input logic [DB-1:0] dv, input logic bad_par, input logic bad_stop);
    word_t w;
    hold(1'b0, CPB);
    for (int i = 0; i < DB; i++) hold(dv[i], CPB);
    if (TB_PARITY != 0) hold((^dv) ^ (TB_PARITY == 2) ^ bad_par, CPB);
    w.data = dv;
    w.ferr = bad_stop;
    w.perr = (TB_PARITY != 0) && bad_par;
    if (!ready_in && exp_q.size() > 0) ovr_exp++;
    else exp_q.push_back(w);
    for (int i = 0; i < SB; i++) hold(!bad_stop, CPB);
  endtask

  task automatic wait_accepts(input int target, input int budget, input string name);
    int k = 0;
    while (accepts < target && k < budget) begin
      tick();
      k++;
    end
    check(name, accepts, target);
  endtask

  // Compare process: every cycle a word is presented, it must match the model head.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun_err) ovr_seen++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got data 0x%0h with no word expected", data_out);
        end else begin
          check("word", {frame_err, parity_err, data_out},
                {exp_q[0].ferr, exp_q[0].perr, exp_q[0].data});
          if (ready_in) begin
            last_data = data_out;
            last_ferr = frame_err;
            last_perr = parity_err;
            void'(exp_q.pop_front());
            accepts++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    ready_in = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {busy, valid_out, frame_err, parity_err, overrun_err, data_out}, 0);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);
    check("idle_busy", busy, 0);

    // Clean 8N1 frame.
    base = accepts;
    send_frame(8'hA5, 1'b0, 1'b0);
    hold(1'b1, CPB);
    wait_accepts(base + 1, 50, "a5_accept");
    check("a5_data", last_data, 8'hA5);
    check("a5_flags", {last_ferr, last_perr}, 0);

    // Short low glitch: no word, busy returns low quickly.
    base = accepts;
    rx = 1'b0;
    repeat (5) tick();
    check("glitch_busy_hi", busy, 1);
    rx = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check("glitch_busy_lo", busy, 0);
    hold(1'b1, 2 * CPB);
    check("glitch_no_valid", accepts, base);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x03 needs parity bit 0; sending 1 is an error.
    base = accepts;
    send_frame(8'h03, 1'b1, 1'b0);
    hold(1'b1, CPB);
    wait_accepts(base + 1, 50, "par1_accept");
    check("par1_data", last_data, 8'h03);
    check("par1_perr", last_perr, 1);
    send_frame(8'h03, 1'b0, 1'b0);
    hold(1'b1, CPB);
    wait_accepts(base + 2, 50, "par0_accept");
    check("par0_perr", last_perr, 0);
`endif

    // Bad stop bit, line stays low, then recovers before the next frame.
    base = accepts;
    send_frame(8'h5A, 1'b0, 1'b1);
    hold(1'b0, CPB + CPB / 2);
    hold(1'b1, CPB);
    wait_accepts(base + 1, 20, "ferr_accept");
    check("ferr_data", last_data, 8'h5A);
    check("ferr_flag", last_ferr, 1);
    send_frame(8'h11, 1'b0, 1'b0);
    hold(1'b1, CPB);
    wait_accepts(base + 2, 50, "after_ferr_accept");
    check("after_ferr_data", last_data, 8'h11);
    check("after_ferr_flag", last_ferr, 0);

    // Overrun: second word dropped while the first is held.
    ready_in = 1'b0;
    base     = accepts;
    ovr_base = ovr_seen;
    send_frame(8'h11, 1'b0, 1'b0);
    hold(1'b1, CPB);
    send_frame(8'h22, 1'b0, 1'b0);
    hold(1'b1, CPB);
    check("ovr_pulses", ovr_seen - ovr_base, 1);
    check("ovr_hold_valid", valid_out, 1);
    check("ovr_hold_data", data_out, 8'h11);
    ready_in = 1'b1;
    wait_accepts(base + 1, 10, "ovr_accept");
    tick();
    tick();
    check("ovr_valid_drop", valid_out, 0);
    check("ovr_acc_data", last_data, 8'h11);

    // Reset during data bit 4 of 0xFF discards the frame.
    base = accepts;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1, CPB);
    hold(1'b1, CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) tick();
    check("rst_mid_state", {busy, valid_out}, 0);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);
    check("rst_no_valid", accepts, base);
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b1, CPB);
    wait_accepts(base + 1, 50, "post_rst_accept");
    check("post_rst_data", last_data, 8'h3C);

    // Random frames: data, parity/stop corruption and ready_in per frame.
    repeat (30) begin
      d        = DB'($urandom);
      bp       = ($urandom_range(3) == 0);
      bs       = ($urandom_range(4) == 0);
      ready_in = ($urandom_range(3) != 0);
      send_frame(d, bp, bs);
      if (bs) hold(1'b0, $urandom_range(CPB, CPB / 2));
      hold(1'b1, $urandom_range(2 * CPB, CPB));
    end
    ready_in = 1'b1;
    hold(1'b1, 4 * CPB);
    check("drain_empty", exp_q.size(), 0);
    check("ovr_total", ovr_seen, ovr_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
